// File: rtl/mimo_fixed_pkg.sv
// Shared fixed-point types, limits, saturation helper and solver FSM states.
// Data is signed two's-complement Q(32-FRAC_BITS).FRAC_BITS held in fxp_t.
package mimo_fixed_pkg;

    typedef logic signed [31:0] fxp_t;

    localparam fxp_t FXP_MAX = 32'sh7FFF_FFFF;
    localparam fxp_t FXP_MIN = 32'sh8000_0000;

    localparam int ACC_W = 40;
    localparam int SUM_W = 48;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        ROW,
        COMMIT,
        DONE
    } solver_state_e;

    // Clamp a wide signed value into the 32-bit fixed-point range.
    function automatic fxp_t sat32(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = 48'sh0000_7FFF_FFFF;
        lo = 48'shFFFF_8000_0000;
        if (v > hi)
            return FXP_MAX;
        else if (v < lo)
            return FXP_MIN;
        else
            return v[31:0];
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Fixed-point multiply-accumulate: acc += (a*b) >>> FRAC_BITS, 40-bit accumulator.
// Ports: clk, reset_n (async low), i_clr (priority clear), i_en (accumulate),
//        i_a/i_b (fxp_t operands), o_acc (40-bit signed accumulator).
module fxp_mac
    import mimo_fixed_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  fxp_t                    i_a,
    input  fxp_t                    i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [63:0]      w_a64;
    logic signed [63:0]      w_b64;
    logic signed [63:0]      w_prod;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] r_acc;

    assign w_a64  = {{32{i_a[31]}}, i_a};
    assign w_b64  = {{32{i_b[31]}}, i_b};
    assign w_prod = w_a64 * w_b64;
    // Rescale the Q.2F product back to Q.F before narrowing to the accumulator.
    assign w_term = ACC_W'(w_prod >>> FRAC_BITS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_term;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/richardson_solver.sv
// Richardson iterative solver for 4x4 A*x=b: x += (b - A*x) >>> MU_SHIFT, x(0)=0.
// One MAC per cycle, Jacobi update, 21 cycles per iteration.
// Ports: clk, reset_n (async low); in_valid/in_ready + matrix_A[16x32] + vector_b[4x32]
//        (element i at bits [i*32 +: 32], A element (r,c) at index r*4+c);
//        out_valid/out_ready + x_out[4x32] + iters_done[8].
// Option: define RICHARDSON_EARLY_EXIT_EN to stop once an iteration changes nothing.
module richardson_solver
    import mimo_fixed_pkg::*;
#(
    parameter int FRAC_BITS = 16,
    parameter int MU_SHIFT  = 2,
    parameter int NUM_ITER  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] matrix_A,
    input  logic [127:0] vector_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] x_out,
    output logic [7:0]   iters_done
);

    solver_state_e r_state;
    solver_state_e w_next;

    fxp_t         r_a  [16];
    fxp_t         r_b  [4];
    fxp_t         r_x  [4];
    fxp_t         r_xn [4];
    logic [1:0]   r_row;
    logic [1:0]   r_col;
    logic [7:0]   r_iter;
    logic [127:0] r_x_out;
    logic [7:0]   r_iters;

    logic                    w_accept;
    logic                    w_acc_clr;
    logic                    w_acc_en;
    fxp_t                    w_a_op;
    fxp_t                    w_x_op;
    fxp_t                    w_b_row;
    fxp_t                    w_x_row;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_diff;
    logic signed [ACC_W-1:0] w_d;
    logic signed [SUM_W-1:0] w_sum;
    fxp_t                    w_xnew;
    logic                    w_last;
    logic                    w_exit;

`ifdef RICHARDSON_EARLY_EXIT_EN
    // Stays set while every row update of the current iteration was zero.
    logic r_allz;
`endif

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    assign w_a_op  = r_a[{r_row, r_col}];
    assign w_x_op  = r_x[r_col];
    assign w_b_row = r_b[r_row];
    assign w_x_row = r_x[r_row];

    assign w_acc_en  = (r_state == MAC);
    assign w_acc_clr = (r_state == ROW) || w_accept;

    fxp_mac #(
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_acc_clr),
        .i_en    (w_acc_en),
        .i_a     (w_a_op),
        .i_b     (w_x_op),
        .o_acc   (w_acc)
    );

    // Residual is formed at accumulator width before the step-size shift.
    assign w_diff = $signed({{8{w_b_row[31]}}, w_b_row}) - w_acc;
    assign w_d    = w_diff >>> MU_SHIFT;
    assign w_sum  = $signed({{16{w_x_row[31]}}, w_x_row})
                  + $signed({{8{w_d[ACC_W-1]}}, w_d});
    assign w_xnew = sat32(w_sum);

    assign w_last = (r_iter == 8'(NUM_ITER - 1));
`ifdef RICHARDSON_EARLY_EXIT_EN
    assign w_exit = w_last || r_allz;
`else
    assign w_exit = w_last;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = MAC;
            MAC:     if (r_col == 2'd3) w_next = ROW;
            ROW:     w_next = (r_row == 2'd3) ? COMMIT : MAC;
            COMMIT:  w_next = w_exit ? DONE : MAC;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                r_a[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                r_b[i]  <= '0;
                r_x[i]  <= '0;
                r_xn[i] <= '0;
            end
            r_row   <= '0;
            r_col   <= '0;
            r_iter  <= '0;
            r_x_out <= '0;
            r_iters <= '0;
`ifdef RICHARDSON_EARLY_EXIT_EN
            r_allz  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++)
                            r_a[i] <= matrix_A[i*32 +: 32];
                        for (int i = 0; i < 4; i++) begin
                            r_b[i]  <= vector_b[i*32 +: 32];
                            r_x[i]  <= '0;
                            r_xn[i] <= '0;
                        end
                        r_row  <= '0;
                        r_col  <= '0;
                        r_iter <= '0;
`ifdef RICHARDSON_EARLY_EXIT_EN
                        r_allz <= 1'b1;
`endif
                    end
                end
                MAC: begin
                    r_col <= r_col + 2'd1;
                end
                ROW: begin
                    r_xn[r_row] <= w_xnew;
                    r_row       <= r_row + 2'd1;
`ifdef RICHARDSON_EARLY_EXIT_EN
                    if (w_d != '0)
                        r_allz <= 1'b0;
`endif
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++)
                        r_x[i] <= r_xn[i];
                    r_iter <= r_iter + 8'd1;
                    r_row  <= '0;
`ifdef RICHARDSON_EARLY_EXIT_EN
                    r_allz <= 1'b1;
`endif
                    if (w_exit) begin
                        for (int i = 0; i < 4; i++)
                            r_x_out[i*32 +: 32] <= r_xn[i];
                        r_iters <= r_iter + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = (r_state == DONE);
    assign x_out      = r_x_out;
    assign iters_done = r_iters;

endmodule

// File: tb/tb_richardson_solver.sv
// Self-checking bench for richardson_solver: directed table, random vs. model,
// throughput, back-pressure and mid-solve reset sequences.
module tb_richardson_solver;

    localparam int FRAC = 16;
    localparam int NI   = 3;
`ifdef RICHARDSON_EARLY_EXIT_EN
    localparam int ID_IT = 2;
`else
    localparam int ID_IT = 8;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [511:0] mat_a     [NI];
    logic [127:0] vec_b     [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] x_out     [NI];
    logic [7:0]   iters     [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    richardson_solver #(.FRAC_BITS(16), .MU_SHIFT(0), .NUM_ITER(8)) u0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .matrix_A(mat_a[0]), .vector_b(vec_b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .x_out(x_out[0]), .iters_done(iters[0]));

    richardson_solver #(.FRAC_BITS(16), .MU_SHIFT(2), .NUM_ITER(8)) u1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .matrix_A(mat_a[1]), .vector_b(vec_b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .x_out(x_out[1]), .iters_done(iters[1]));

    richardson_solver #(.FRAC_BITS(16), .MU_SHIFT(0), .NUM_ITER(2)) u2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .matrix_A(mat_a[2]), .vector_b(vec_b[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .x_out(x_out[2]), .iters_done(iters[2]));

    typedef struct {
        int           k;
        logic [511:0] a;
        logic [127:0] b;
        logic [127:0] x;
        int           it;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] diag(input logic [31:0] v);
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            m[(i*5)*32 +: 32] = v;
        return m;
    endfunction

    function automatic logic [127:0] rep4(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    // Reference: plain integer Richardson iteration straight from the math.
    function automatic void model(input logic [511:0] a, input logic [127:0] b,
                                  input int mu, input int n,
                                  output logic [127:0] xo, output int it);
        longint x [4];
        longint xn [4];
        longint acc;
        longint d;
        longint s;
        bit     allz;
        for (int i = 0; i < 4; i++) x[i] = 0;
        it = 0;
        for (int k = 0; k < n; k++) begin
            allz = 1;
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int c = 0; c < 4; c++)
                    acc += (longint'(signed'(a[(r*4+c)*32 +: 32])) * x[c]) >>> FRAC;
                d = (longint'(signed'(b[r*32 +: 32])) - acc) >>> mu;
                if (d != 0) allz = 0;
                s = x[r] + d;
                if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
                if (s < -64'sh8000_0000) s = -64'sh8000_0000;
                xn[r] = s;
            end
            for (int i = 0; i < 4; i++) x[i] = xn[i];
            it = k + 1;
`ifdef RICHARDSON_EARLY_EXIT_EN
            if (allz) break;
`endif
        end
        for (int i = 0; i < 4; i++) xo[i*32 +: 32] = x[i][31:0];
    endfunction

    // Caller sits #1 after a rising edge; returns #1 after the accept edge.
    task automatic start(input int k, input logic [511:0] a, input logic [127:0] b);
        int n;
        n = 0;
        while (!in_ready[k] && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 128'(in_ready[k]), 128'(1));
        mat_a[k] = a;
        vec_b[k] = b;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        mat_a[k] = {16{$urandom()}};
        vec_b[k] = {4{$urandom()}};
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid[k] && lat < 3000);
        if (!out_valid[k])
            chk("done_timeout", 128'(out_valid[k]), 128'(1));
    endtask

    task automatic run(input int k, input logic [511:0] a, input logic [127:0] b,
                       output logic [127:0] x, output int it, output int lat);
        start(k, a, b);
        wait_done(k, lat);
        x  = x_out[k];
        it = int'(iters[k]);
        chk("busy_in_ready", 128'(in_ready[k]), 128'(0));
        @(posedge clk); #1;
        chk("post_valid", 128'(out_valid[k]), 128'(0));
        chk("post_ready", 128'(in_ready[k]), 128'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [4];
        logic [127:0] x;
        logic [127:0] xe;
        logic [127:0] snap;
        int           it;
        int           ite;
        int           lat;
        int           t1;
        int           t2;
        int           t;
        logic         prev;
        logic [511:0] ra;
        logic [127:0] rb;
        logic [127:0] b_id;

        b_id = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        tbl[0] = '{0, diag(32'h0001_0000), b_id, b_id, ID_IT};
        tbl[1] = '{1, diag(32'h0002_0000), rep4(32'h0002_0000),
                   rep4(32'h0000_FF00), 8};
        tbl[2] = '{2, '0, rep4(32'h7FFF_0000), rep4(32'h7FFF_FFFF), 2};
        tbl[3] = '{2, '0, rep4(32'h8001_0000), rep4(32'h8000_0000), 2};

        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            mat_a[k]     = '0;
            vec_b[k]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
            chk("rst_in_ready", 128'(in_ready[k]), 128'(1));
            chk("rst_x_out", x_out[k], 128'(0));
            chk("rst_iters", 128'(iters[k]), 128'(0));
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run(tbl[i].k, tbl[i].a, tbl[i].b, x, it, lat);
            chk($sformatf("tbl%0d_x", i), x, tbl[i].x);
            chk($sformatf("tbl%0d_iters", i), 128'(it), 128'(tbl[i].it));
            chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(tbl[i].it * 21));
        end

        for (int n = 0; n < 8; n++) begin
            ra = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (r == c)
                        ra[(r*4+c)*32 +: 32] = 32'(32'h2_0000 + $urandom_range(0, 32'h2_0000));
                    else
                        ra[(r*4+c)*32 +: 32] = 32'(int'($urandom_range(0, 32'h8000)) - 32'h4000);
            for (int r = 0; r < 4; r++)
                rb[r*32 +: 32] = 32'(int'($urandom_range(0, 32'h8_0000)) - 32'h4_0000);
            model(ra, rb, 2, 8, xe, ite);
            run(1, ra, rb, x, it, lat);
            chk($sformatf("rnd%0d_x", n), x, xe);
            chk($sformatf("rnd%0d_iters", n), 128'(it), 128'(ite));
            chk($sformatf("rnd%0d_lat", n), 128'(lat), 128'(ite * 21));
        end

        // Back-to-back throughput with in_valid and out_ready held high.
        mat_a[1] = diag(32'h0002_0000);
        vec_b[1] = rep4(32'h0002_0000);
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        t1 = -1; t2 = -1; t = 0; prev = 1'b0;
        while (t2 < 0 && t < 1000) begin
            @(posedge clk); #1; t++;
            if (out_valid[1] && !prev) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
            prev = out_valid[1];
        end
        in_valid[1] = 1'b0;
        chk("thru_first", 128'(t1), 128'(168));
        chk("thru_second", 128'(t2), 128'(338));
        chk("thru_x", x_out[1], rep4(32'h0000_FF00));
        @(posedge clk); #1;
        chk("thru_idle", 128'(in_ready[1]), 128'(1));

        // Back-pressure: hold DONE, offer a second problem meanwhile.
        out_ready[1] = 1'b0;
        start(1, diag(32'h0002_0000), rep4(32'h0002_0000));
        wait_done(1, lat);
        chk("bp_lat", 128'(lat), 128'(168));
        snap = x_out[1];
        chk("bp_x", snap, rep4(32'h0000_FF00));
        mat_a[1] = diag(32'h0001_0000);
        vec_b[1] = b_id;
        in_valid[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", 128'(out_valid[1]), 128'(1));
            chk("bp_hold_x", x_out[1], snap);
            chk("bp_in_ready", 128'(in_ready[1]), 128'(0));
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 128'(out_valid[1]), 128'(0));
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        chk("bp_accepted", 128'(in_ready[1]), 128'(0));
        wait_done(1, lat);
        model(diag(32'h0001_0000), b_id, 2, 8, xe, ite);
        chk("bp2_lat", 128'(lat), 128'(ite * 21));
        chk("bp2_x", x_out[1], xe);
        chk("bp2_iters", 128'(iters[1]), 128'(ite));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of iteration 3.
        start(1, diag(32'h0002_0000), rep4(32'h0002_0000));
        repeat (3 * 21 + 5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid[1]), 128'(0));
        chk("mid_rst_ready", 128'(in_ready[1]), 128'(1));
        chk("mid_rst_x", x_out[1], 128'(0));
        chk("mid_rst_iters", 128'(iters[1]), 128'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run(1, diag(32'h0002_0000), rep4(32'h0002_0000), x, it, lat);
        chk("rerun_x", x, rep4(32'h0000_FF00));
        chk("rerun_iters", 128'(it), 128'(8));
        chk("rerun_lat", 128'(lat), 128'(168));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
